// File: rtl/io_arbiter.sv
// Three-requester round-robin arbiter in front of the single-port io register bus.
// Optional bus locking for atomic read-modify-write is enabled with `define IO_ARB_LOCK_EN.
module io_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    input  logic [2:0]      lock,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic [AW-1:0]   io_address,
    output logic [DW-1:0]   io_din,
    output logic            io_w_en,
    output logic            io_r_en,
    input  logic [DW-1:0]   io_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [1:0]      ptr_r, win_r;
    logic [2:0]      gnt_r, rvalid_r;
    logic [DW-1:0]   rdata_r, io_din_r, sel_wdata_s;
    logic [AW-1:0]   io_address_r, sel_addr_s;
    logic            io_w_en_r, io_r_en_r, sel_we_s;
    logic [2:0]      elig_s;
    logic            pick_vld_s;
    logic [1:0]      pick_idx_s, c1_s, c2_s;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        case (i)
            2'd0:    next_idx = 2'd1;
            2'd1:    next_idx = 2'd2;
            default: next_idx = 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] to_onehot(input logic [1:0] i);
        case (i)
            2'd0:    to_onehot = 3'b001;
            2'd1:    to_onehot = 3'b010;
            2'd2:    to_onehot = 3'b100;
            default: to_onehot = 3'b000;
        endcase
    endfunction

    function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
        case (i)
            2'd0:    bit_at = v[0];
            2'd1:    bit_at = v[1];
            2'd2:    bit_at = v[2];
            default: bit_at = 1'b0;
        endcase
    endfunction

`ifdef IO_ARB_LOCK_EN
    logic locked_r;

    // While locked only the lock owner (last winner) may be granted
    always_comb begin
        if (locked_r) begin
            elig_s = req & to_onehot(win_r);
        end else begin
            elig_s = req;
        end
    end
`else
    logic unused_lock_s;
    assign unused_lock_s = ^lock;

    // Pure round-robin: every requester is always eligible
    always_comb begin
        elig_s = req;
    end
`endif

    // Round-robin search starting at ptr
    always_comb begin
        c1_s       = next_idx(ptr_r);
        c2_s       = next_idx(c1_s);
        pick_vld_s = 1'b1;
        pick_idx_s = ptr_r;
        if (bit_at(elig_s, ptr_r)) begin
            pick_idx_s = ptr_r;
        end else if (bit_at(elig_s, c1_s)) begin
            pick_idx_s = c1_s;
        end else if (bit_at(elig_s, c2_s)) begin
            pick_idx_s = c2_s;
        end else begin
            pick_vld_s = 1'b0;
        end
    end

    // Winner's access fields
    always_comb begin
        case (pick_idx_s)
            2'd1: begin
                sel_addr_s  = addr[2*AW-1:AW];
                sel_wdata_s = wdata[2*DW-1:DW];
                sel_we_s    = we[1];
            end
            2'd2: begin
                sel_addr_s  = addr[3*AW-1:2*AW];
                sel_wdata_s = wdata[3*DW-1:2*DW];
                sel_we_s    = we[2];
            end
            default: begin
                sel_addr_s  = addr[AW-1:0];
                sel_wdata_s = wdata[DW-1:0];
                sel_we_s    = we[0];
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_vld_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (io_w_en_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = CAPTURE;
                end
            end
            CAPTURE: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant, strobe, pointer and read-capture registers; strobes and pulses default low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r        <= 2'd0;
            win_r        <= 2'd0;
            gnt_r        <= 3'b000;
            rvalid_r     <= 3'b000;
            rdata_r      <= {DW{1'b0}};
            io_address_r <= {AW{1'b0}};
            io_din_r     <= {DW{1'b0}};
            io_w_en_r    <= 1'b0;
            io_r_en_r    <= 1'b0;
`ifdef IO_ARB_LOCK_EN
            locked_r     <= 1'b0;
`endif
        end else begin
            gnt_r     <= 3'b000;
            rvalid_r  <= 3'b000;
            io_w_en_r <= 1'b0;
            io_r_en_r <= 1'b0;
            if (state_r == IDLE && pick_vld_s) begin
                gnt_r        <= to_onehot(pick_idx_s);
                win_r        <= pick_idx_s;
                io_address_r <= sel_addr_s;
                io_din_r     <= sel_wdata_s;
                io_w_en_r    <= sel_we_s;
                io_r_en_r    <= ~sel_we_s;
`ifdef IO_ARB_LOCK_EN
                // A locked grant freezes ptr; the releasing grant advances it
                locked_r <= bit_at(lock, pick_idx_s);
                if (bit_at(lock, pick_idx_s)) begin
                    ptr_r <= ptr_r;
                end else begin
                    ptr_r <= next_idx(pick_idx_s);
                end
`else
                ptr_r <= next_idx(pick_idx_s);
`endif
            end
            if (state_r == CAPTURE) begin
                rdata_r  <= io_dout;
                rvalid_r <= to_onehot(win_r);
            end
        end
    end

    assign gnt        = gnt_r;
    assign rvalid     = rvalid_r;
    assign rdata      = rdata_r;
    assign io_address = io_address_r;
    assign io_din     = io_din_r;
    assign io_w_en    = io_w_en_r;
    assign io_r_en    = io_r_en_r;

endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter with a small registered io register-file model.
module tb_io_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      req, we, lock;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt, rvalid;
    logic [DW-1:0]   rdata, io_din, io_dout;
    logic [AW-1:0]   io_address;
    logic            io_w_en, io_r_en;
    logic [DW-1:0]   mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .lock(lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .io_address(io_address), .io_din(io_din), .io_w_en(io_w_en),
        .io_r_en(io_r_en), .io_dout(io_dout)
    );

    // io block model: registered read data the cycle after r_en
    always @(posedge clk) begin
        if (io_w_en) mem[io_address] <= io_din;
        if (io_r_en) io_dout <= mem[io_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] fair_ord [6];
    logic [2:0] lock_ord [4];
    logic       got;

    initial begin
        fair_ord[0] = 3'b001; fair_ord[1] = 3'b010; fair_ord[2] = 3'b100;
        fair_ord[3] = 3'b001; fair_ord[4] = 3'b010; fair_ord[5] = 3'b100;
`ifdef IO_ARB_LOCK_EN
        lock_ord[0] = 3'b010; lock_ord[1] = 3'b010; lock_ord[2] = 3'b100; lock_ord[3] = 3'b001;
`else
        lock_ord[0] = 3'b010; lock_ord[1] = 3'b100; lock_ord[2] = 3'b001; lock_ord[3] = 3'b010;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[5] = 8'h3C;
        io_dout = 8'h00;
        req = 3'b000; we = 3'b000; lock = 3'b000; addr = '0; wdata = '0;
        rst_n = 1'b0;
        tick; tick;
        check("rst_gnt", {29'd0, gnt}, 32'd0);
        check("rst_rvalid", {29'd0, rvalid}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_bus", {14'd0, io_address, io_din, io_w_en, io_r_en}, 32'd0);
        rst_n = 1'b1;
        tick;

        // Single write by requester 0
        req = 3'b001; we = 3'b001; addr[7:0] = 8'h01; wdata[7:0] = 8'hA5;
        tick;
        check("wr_gnt", {29'd0, gnt}, 32'h1);
        check("wr_wen", {30'd0, io_w_en, io_r_en}, 32'h2);
        check("wr_addr", {24'd0, io_address}, 32'h01);
        check("wr_din", {24'd0, io_din}, 32'hA5);
        check("wr_rvalid", {29'd0, rvalid}, 32'd0);
        req = 3'b000;
        tick;
        check("wr_idle", {27'd0, gnt, io_w_en, io_r_en}, 32'd0);
        check("wr_hold_addr", {24'd0, io_address}, 32'h01);

        // Single read by requester 2
        req = 3'b100; we = 3'b000; addr[23:16] = 8'h05;
        tick;
        check("rd_gnt", {29'd0, gnt}, 32'h4);
        check("rd_ren", {30'd0, io_w_en, io_r_en}, 32'h1);
        check("rd_addr", {24'd0, io_address}, 32'h05);
        req = 3'b000;
        tick;
        check("rd_cap", {27'd0, gnt, io_w_en, io_r_en}, 32'd0);
        check("rd_early", {29'd0, rvalid}, 32'd0);
        tick;
        check("rd_rvalid", {29'd0, rvalid}, 32'h4);
        check("rd_rdata", {24'd0, rdata}, 32'h3C);
        tick;
        check("rd_pulse", {29'd0, rvalid}, 32'd0);
        check("rd_hold", {24'd0, rdata}, 32'h3C);

        // Fairness and wrap: all three write continuously
        req = 3'b111; we = 3'b111;
        addr = {8'h12, 8'h11, 8'h10}; wdata = {8'h22, 8'h21, 8'h20};
        for (int k = 0; k < 6; k++) begin
            tick;
            check("rr_gnt", {29'd0, gnt}, {29'd0, fair_ord[k]});
            check("rr_excl", {31'd0, io_w_en & io_r_en}, 32'd0);
            check("rr_addr", {24'd0, io_address}, 32'h10 + ((k % 3)));
            check("rr_din", {24'd0, io_din}, 32'h20 + ((k % 3)));
            if (k == 5) req = 3'b000;
            tick;
            check("rr_gap", {29'd0, gnt}, 32'd0);
        end

        // Reset during CAPTURE of a read by requester 1
        req = 3'b010; we = 3'b000; addr[15:8] = 8'h01;
        tick;
        check("rst_rd_gnt", {29'd0, gnt}, 32'h2);
        req = 3'b000;
        tick;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out", {27'd0, gnt, io_w_en, io_r_en}, 32'd0);
        check("rst_mid_rv", {29'd0, rvalid}, 32'd0);
        tick;
        check("rst_mid_rv2", {29'd0, rvalid}, 32'd0);
        rst_n = 1'b1;
        req = 3'b111; we = 3'b111;
        tick;
        check("rst_first", {29'd0, gnt}, 32'h1);
        req = 3'b000;
        tick;

        // Lock: requester 1 read with lock, then write without, others waiting
        req = 3'b010; we = 3'b000; lock = 3'b010; addr[15:8] = 8'h01;
        tick;
        check("lk_gnt0", {29'd0, gnt}, {29'd0, lock_ord[0]});
        req = 3'b111; we = 3'b111; lock = 3'b000;
        for (int k = 1; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                tick;
                if (gnt != 3'b000) got = 1'b1;
            end
            check("lk_wait", {31'd0, got}, 32'd1);
            check("lk_gnt", {29'd0, gnt}, {29'd0, lock_ord[k]});
        end
        req = 3'b000;
        tick; tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
